// File: rtl/ram_io_pkg.sv
// Shared encodings for the RAM I/O sequencer: access sizes, FSM states, lane masks.
// Latency: none (types and constants only).
// Backpressure: n/a.
package ram_io_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_RSVD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS1 = 2'd1,
        ACCESS2 = 2'd2,
        RESP    = 2'd3
    } state_e;

    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;
    localparam logic [3:0] MASK_NONE = 4'b0000;

    // Unshifted lane mask for an access size; reserved size touches no lanes.
    function automatic logic [3:0] size_mask(input size_e size);
        case (size)
            SIZE_BYTE: return MASK_BYTE;
            SIZE_HALF: return MASK_HALF;
            SIZE_WORD: return MASK_WORD;
            default:   return MASK_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ram_io_sequencer_if.sv
// CPU-side request/response bundle of the RAM I/O sequencer.
// Latency: none (wires only).
// Backpressure: req_valid/req_ready handshake; rsp_valid is a one-shot pulse with no ready.
interface ram_io_sequencer_if
    import ram_io_pkg::*;
#(
    parameter int ADDR_W = 18
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_address;
    logic [DATA_W-1:0] req_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_address, req_data,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_address, req_data,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/ram_io_sequencer_byte_lane_aligner.sv
// Maps (size, lane offset, phase) to RAM byte enables and lane-shifted store data.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle from the latched request.
module byte_lane_aligner
    import ram_io_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  off,
    input  logic        phase,
    input  logic [31:0] data,
    output logic [3:0]  enables,
    output logic [31:0] store_data,
    output logic        span
);
    logic [7:0]  mask_wide;
    logic [63:0] data_wide;

    // Shift mask and data across a two-word window; the upper half is what spills into word+1.
    always_comb begin
        mask_wide  = {4'b0000, size_mask(size)} << off;
        data_wide  = {32'd0, data} << {off, 3'b000};
        span       = |mask_wide[7:4];
        enables    = phase ? mask_wide[7:4]   : mask_wide[3:0];
        store_data = phase ? data_wide[63:32] : data_wide[31:0];
    end
endmodule

// File: rtl/ram_io_sequencer.sv
// Turns byte-addressed CPU loads/stores into word RAM accesses, splitting word-crossing ones in two.
// Latency: rsp_valid in the 2nd cycle after accept (3rd when the access spans two words).
// Backpressure: req_ready only in IDLE; one request in flight, nothing queued.
module ram_io_sequencer
    import ram_io_pkg::*;
#(
    parameter int RAM_ADDRESS_BITWIDTH = 16,
    parameter int DATA_BITWIDTH        = 32,
    parameter int COLUMN_BITWIDTH      = 8
) (
    input  logic                                      clk,
    input  logic                                      rst,
    ram_io_sequencer_if.slave                         bus,
    output logic [RAM_ADDRESS_BITWIDTH-1:0]           ram_address,
    output logic [DATA_BITWIDTH/COLUMN_BITWIDTH-1:0]  ram_write_enable,
    output logic [DATA_BITWIDTH-1:0]                  ram_data_in,
    input  logic [DATA_BITWIDTH-1:0]                  ram_data_out
);
    if (DATA_BITWIDTH != 32 || COLUMN_BITWIDTH != 8) begin : g_param_check
        $error("ram_io_sequencer: DATA_BITWIDTH must be 32 and COLUMN_BITWIDTH must be 8");
    end

    localparam int AW = RAM_ADDRESS_BITWIDTH;

    state_e      state;
    state_e      state_next;
    logic        accept;
    logic        ready_c;
    logic        rsp_valid_c;
    logic        in_access;
    logic        phase;

    logic        lat_write;
    size_e       lat_size;
    logic        lat_signed;
    logic [1:0]  lat_off;
    logic [31:0] lat_data;

    logic [31:0] hold;
    logic [31:0] rsp_data_q;
    logic [63:0] load_shift;
    logic [31:0] load_word;

    logic [3:0]  lane_en;
    logic [31:0] lane_data;
    logic        span;

    byte_lane_aligner u_aligner (
        .size       (lat_size),
        .off        (lat_off),
        .phase      (phase),
        .data       (lat_data),
        .enables    (lane_en),
        .store_data (lane_data),
        .span       (span)
    );

    // Next state and per-state strobes; reserved size walks the FSM without touching the RAM.
    always_comb begin
        state_next  = state;
        ready_c     = 1'b0;
        rsp_valid_c = 1'b0;
        in_access   = 1'b0;
        phase       = 1'b0;
        case (state)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.req_valid) state_next = ACCESS1;
            end
            ACCESS1: begin
                in_access  = (lat_size != SIZE_RSVD);
                state_next = span ? ACCESS2 : RESP;
            end
            ACCESS2: begin
                in_access  = 1'b1;
                phase      = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                rsp_valid_c = 1'b1;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = (state == IDLE) && bus.req_valid;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Capture the whole request at accept so later input wiggles are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_write  <= 1'b0;
            lat_size   <= SIZE_BYTE;
            lat_signed <= 1'b0;
            lat_off    <= 2'd0;
            lat_data   <= 32'd0;
        end else if (accept) begin
            lat_write  <= bus.req_write;
            lat_size   <= size_e'(bus.req_size);
            lat_signed <= bus.req_signed;
            lat_off    <= bus.req_address[1:0];
            lat_data   <= bus.req_data;
        end
    end

    // Word address is registered so it is already stable during each ACCESS cycle; wraps at the top.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_address <= '0;
        end else if (accept && size_e'(bus.req_size) != SIZE_RSVD) begin
            ram_address <= bus.req_address[AW+1:2];
        end else if (state == ACCESS1 && span) begin
            ram_address <= ram_address + {{(AW-1){1'b0}}, 1'b1};
        end
    end

    // Write strobes and data only while an access phase of a store is active.
    always_comb begin
        ram_write_enable = '0;
        ram_data_in      = '0;
        if (in_access && lat_write) begin
            ram_write_enable = lane_en;
            ram_data_in      = lane_data;
        end
    end

    // Upper half: read word moved down to lane 0; lower half: read word moved up past the first part.
    always_comb begin
        load_shift = {ram_data_out, 32'd0} >> {lat_off, 3'b000};
        load_word  = (state == ACCESS2) ? (hold | load_shift[31:0]) : load_shift[63:32];
    end

    // Holding register keeps the first-word bytes of a spanning load.
    always_ff @(posedge clk) begin
        if (rst)                  hold <= 32'd0;
        else if (state == ACCESS1) hold <= load_shift[63:32];
    end

    function automatic logic [31:0] extend_load(input size_e size, input logic sgn,
                                                input logic [31:0] w);
        case (size)
            SIZE_BYTE: return {{24{sgn & w[7]}}, w[7:0]};
            SIZE_HALF: return {{16{sgn & w[15]}}, w[15:0]};
            SIZE_WORD: return w;
            default:   return 32'd0;
        endcase
    endfunction

    // Response data is loaded only on entry to RESP so it stays put until the next response.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data_q <= 32'd0;
        end else if (state_next == RESP && state != RESP) begin
            rsp_data_q <= lat_write ? 32'd0 : extend_load(lat_size, lat_signed, load_word);
        end
    end

    assign bus.req_ready = ready_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_data  = rsp_data_q;

endmodule
